// File: rtl/sample_window_shifter_pkg.sv
// Shared sizing helpers for the sample window shifter and the downstream
// correlators that consume its taps.
package sample_window_pkg;

  // Width of one sample word: enough bits for SAMPLES*OSF plus one extra bit.
  function automatic int word_w(input int samples, input int osf);
    return $clog2(samples * osf) + 1;
  endfunction

  // Width of a fill counter that has to hold values 0..depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sample_window_shifter_if.sv
// Data/control bundle between a sample producer and the window shifter.
interface sample_window_shifter_if #(
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 3,
  parameter int WORD_W   = 5,
  parameter int CNT_W    = 2
);
  logic                             InValid;
  logic [CHANNELS*WORD_W-1:0]       DataIn;
  logic                             Hold;
  logic                             Flush;
  logic [CHANNELS*DEPTH*WORD_W-1:0] DataOut;
  logic [CNT_W-1:0]                 FillCount;
  logic                             WindowValid;
  logic                             OutValid;
  logic                             Overrun;

  modport master (
    output InValid, DataIn, Hold, Flush,
    input  DataOut, FillCount, WindowValid, OutValid, Overrun
  );

  modport slave (
    input  InValid, DataIn, Hold, Flush,
    output DataOut, FillCount, WindowValid, OutValid, Overrun
  );
endinterface

// File: rtl/sample_window_shifter_lane.sv
// One channel's tap-delay line: DEPTH words, tap 0 is the newest sample.
module sample_window_lane #(
  parameter int DEPTH  = 3,
  parameter int WORD_W = 5
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Clr,
  input  logic                    Shift,
  input  logic [WORD_W-1:0]       Din,
  output logic [DEPTH*WORD_W-1:0] Dout
);

  logic [DEPTH-1:0][WORD_W-1:0] taps_q;
  logic [DEPTH-1:0][WORD_W-1:0] taps_d;

  // Next tap contents: clear wins, otherwise shift older by one and load Din.
  always_comb begin
    taps_d = taps_q;
    if (Clr) begin
      taps_d = '0;
    end else if (Shift) begin
      for (int k = 1; k < DEPTH; k++) begin
        taps_d[k] = taps_q[k-1];
      end
      taps_d[0] = Din;
    end
  end

  // Tap register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) taps_q <= '0;
    else       taps_q <= taps_d;
  end

  assign Dout = taps_q;

endmodule

// File: rtl/sample_window_shifter.sv
// Multi-channel tap-delay window with fill tracking, stride-decimated
// strobes, hold/flush control and sticky overrun detection.
module sample_window_shifter
  import sample_window_pkg::*;
#(
  parameter int SAMPLES  = 2,
  parameter int OSF      = 8,
  parameter int DEPTH    = 3,
  parameter int CHANNELS = 2,
  parameter int STRIDE   = 1
) (
  input logic               Clk,
  input logic               Reset,
  sample_window_shifter_if.slave bus
);

  localparam int WORD_W = word_w(SAMPLES, OSF);
  localparam int CNT_W  = cnt_w(DEPTH);
  localparam int SCW    = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  logic             shift_event;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic [SCW-1:0]   stride_q, stride_d;
  logic             win_valid_q, win_valid_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;
  logic [CHANNELS*DEPTH*WORD_W-1:0] data_out;

  // Reset is applied inside the flops, so it needs no term here.
  assign shift_event = bus.InValid & ~bus.Hold & ~bus.Flush;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    sample_window_lane #(
      .DEPTH  (DEPTH),
      .WORD_W (WORD_W)
    ) u_lane (
      .Clk   (Clk),
      .Reset (Reset),
      .Clr   (bus.Flush),
      .Shift (shift_event),
      .Din   (bus.DataIn[c*WORD_W +: WORD_W]),
      .Dout  (data_out[c*DEPTH*WORD_W +: DEPTH*WORD_W])
    );
  end

  // Shared control: fill level, stride countdown, strobe and overrun flag.
  always_comb begin
    fill_d      = fill_q;
    stride_d    = stride_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;
    if (bus.Flush) begin
      fill_d    = '0;
      stride_d  = '0;
      overrun_d = 1'b0;
    end else if (bus.Hold) begin
      if (bus.InValid) overrun_d = 1'b1;
    end else if (shift_event) begin
      if (fill_q != CNT_W'(DEPTH)) fill_d = fill_q + 1'b1;
      if (fill_d == CNT_W'(DEPTH)) begin
        if (stride_q == '0) begin
          out_valid_d = 1'b1;
          stride_d    = SCW'(STRIDE - 1);
        end else begin
          stride_d = stride_q - 1'b1;
        end
      end
    end
    win_valid_d = (fill_d == CNT_W'(DEPTH));
  end

  // Control registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fill_q      <= '0;
      stride_q    <= '0;
      win_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      fill_q      <= fill_d;
      stride_q    <= stride_d;
      win_valid_q <= win_valid_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.DataOut     = data_out;
  assign bus.FillCount   = fill_q;
  assign bus.WindowValid = win_valid_q;
  assign bus.OutValid    = out_valid_q;
  assign bus.Overrun     = overrun_q;

endmodule

// File: tb/tb_sample_window_shifter.sv
// Self-checking bench for sample_window_shifter: directed scenarios followed
// by a random phase, all compared against a history-queue reference model.
module tb_sample_window_shifter;
  import sample_window_pkg::*;

  localparam int SAMPLES  = 2;
  localparam int OSF      = 8;
  localparam int DEPTH    = 3;
  localparam int CHANNELS = 2;
  localparam int STRIDE   = 2;
  localparam int WORD_W   = word_w(SAMPLES, OSF);
  localparam int CNT_W    = cnt_w(DEPTH);

  typedef logic [CHANNELS*WORD_W-1:0]       word_vec_t;
  typedef logic [CHANNELS*DEPTH*WORD_W-1:0] window_t;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  sample_window_shifter_if #(
    .CHANNELS (CHANNELS),
    .DEPTH    (DEPTH),
    .WORD_W   (WORD_W),
    .CNT_W    (CNT_W)
  ) bus ();

  sample_window_shifter #(
    .SAMPLES  (SAMPLES),
    .OSF      (OSF),
    .DEPTH    (DEPTH),
    .CHANNELS (CHANNELS),
    .STRIDE   (STRIDE)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: the last DEPTH accepted input vectors, newest first,
  // plus a count of full-window shifts since the last reset/flush.
  word_vec_t hist[$];
  int        full_shifts = 0;
  bit        exp_strobe  = 1'b0;
  bit        exp_overrun = 1'b0;

  task automatic modelStep(input bit rst, input bit iv, input bit hold,
                           input bit flush, input word_vec_t din);
    if (rst || flush) begin
      hist.delete();
      full_shifts = 0;
      exp_strobe  = 1'b0;
      exp_overrun = 1'b0;
    end else if (hold) begin
      exp_strobe = 1'b0;
      if (iv) exp_overrun = 1'b1;
    end else if (iv) begin
      hist.push_front(din);
      if (hist.size() > DEPTH) void'(hist.pop_back());
      if (hist.size() == DEPTH) begin
        full_shifts++;
        exp_strobe = ((full_shifts - 1) % STRIDE) == 0;
      end else begin
        exp_strobe = 1'b0;
      end
    end else begin
      exp_strobe = 1'b0;
    end
  endtask

  function automatic window_t expWindow();
    window_t   r = '0;
    word_vec_t w;
    for (int k = 0; k < hist.size(); k++) begin
      w = hist[k];
      for (int c = 0; c < CHANNELS; c++) begin
        r[(c*DEPTH + k)*WORD_W +: WORD_W] = w[c*WORD_W +: WORD_W];
      end
    end
    return r;
  endfunction

  function automatic word_vec_t mk2(input int ch0, input int ch1);
    word_vec_t v;
    v[0 +: WORD_W]      = WORD_W'(ch0);
    v[WORD_W +: WORD_W] = WORD_W'(ch1);
    return v;
  endfunction

  function automatic logic [WORD_W-1:0] tapOf(input int c, input int k);
    return bus.DataOut[(c*DEPTH + k)*WORD_W +: WORD_W];
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] obs,
                          input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".DataOut"},     64'(bus.DataOut),     64'(expWindow()));
    checkVal({tag, ".FillCount"},   64'(bus.FillCount),   64'(hist.size()));
    checkVal({tag, ".WindowValid"}, 64'(bus.WindowValid), 64'(hist.size() == DEPTH));
    checkVal({tag, ".OutValid"},    64'(bus.OutValid),    64'(exp_strobe));
    checkVal({tag, ".Overrun"},     64'(bus.Overrun),     64'(exp_overrun));
  endtask

  // Drive one cycle of inputs, let the edge happen, update model, then compare.
  task automatic applyStimulus(input string tag, input bit rst, input bit iv,
                               input bit hold, input bit flush,
                               input word_vec_t din);
    Reset       = rst;
    bus.InValid = iv;
    bus.Hold    = hold;
    bus.Flush   = flush;
    bus.DataIn  = din;
    @(posedge Clk);
    modelStep(rst, iv, hold, flush, din);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    word_vec_t ones;
    bit r_rst, r_iv, r_hold, r_flush;
    ones = '1;
    Reset       = 1'b1;
    bus.InValid = 1'b0;
    bus.Hold    = 1'b0;
    bus.Flush   = 1'b0;
    bus.DataIn  = '0;

    $display("[TB] reset with InValid high and all-ones data");
    applyStimulus("t1_rst0", 1, 1, 0, 0, ones);
    applyStimulus("t1_rst1", 1, 1, 0, 0, ones);

    $display("[TB] fill window with 1,2,3 / 11,12,13");
    applyStimulus("t2_push1", 0, 1, 0, 0, mk2(1, 11));
    applyStimulus("t2_push2", 0, 1, 0, 0, mk2(2, 12));
    applyStimulus("t2_push3", 0, 1, 0, 0, mk2(3, 13));
    checkVal("t2_ch0_tap2", 64'(tapOf(0, 2)), 64'd1);
    checkVal("t2_ch0_tap0", 64'(tapOf(0, 0)), 64'd3);
    checkVal("t2_ch1_tap1", 64'(tapOf(1, 1)), 64'd12);
    checkVal("t2_outvalid", 64'(bus.OutValid), 64'd1);

    $display("[TB] stride-decimated strobes on 4,5,6");
    applyStimulus("t3_push4", 0, 1, 0, 0, mk2(4, 14));
    checkVal("t3_nostrobe4", 64'(bus.OutValid), 64'd0);
    applyStimulus("t3_push5", 0, 1, 0, 0, mk2(5, 15));
    checkVal("t3_strobe5", 64'(bus.OutValid), 64'd1);
    applyStimulus("t3_push6", 0, 1, 0, 0, mk2(6, 16));
    checkVal("t3_nostrobe6", 64'(bus.OutValid), 64'd0);
    checkVal("t3_ch0_tap2", 64'(tapOf(0, 2)), 64'd4);
    checkVal("t3_ch0_tap0", 64'(tapOf(0, 0)), 64'd6);

    $display("[TB] hold with InValid raises overrun");
    applyStimulus("t4_hold0", 0, 1, 1, 0, mk2(7, 17));
    applyStimulus("t4_hold1", 0, 1, 1, 0, mk2(8, 18));
    applyStimulus("t4_release", 0, 0, 0, 0, mk2(9, 19));
    checkVal("t4_overrun_sticky", 64'(bus.Overrun), 64'd1);
    checkVal("t4_ch0_tap0", 64'(tapOf(0, 0)), 64'd6);

    $display("[TB] flush with InValid");
    applyStimulus("t5_flush", 0, 1, 0, 1, mk2(10, 20));
    checkVal("t5_fill", 64'(bus.FillCount), 64'd0);
    checkVal("t5_overrun", 64'(bus.Overrun), 64'd0);

    $display("[TB] pushes separated by idle cycles");
    applyStimulus("t6_push7", 0, 1, 0, 0, mk2(7, 27));
    applyStimulus("t6_idle0", 0, 0, 0, 0, mk2(1, 1));
    applyStimulus("t6_idle1", 0, 0, 0, 0, mk2(2, 2));
    applyStimulus("t6_idle2", 0, 0, 0, 0, mk2(3, 3));
    checkVal("t6_fill1", 64'(bus.FillCount), 64'd1);
    applyStimulus("t6_push8", 0, 1, 0, 0, mk2(8, 28));
    checkVal("t6_fill2", 64'(bus.FillCount), 64'd2);
    checkVal("t6_ch0_tap1", 64'(tapOf(0, 1)), 64'd7);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      r_rst   = ($urandom_range(0, 99) < 2);
      r_flush = ($urandom_range(0, 99) < 4);
      r_hold  = ($urandom_range(0, 99) < 12);
      r_iv    = ($urandom_range(0, 99) < 65);
      applyStimulus("rand", r_rst, r_iv, r_hold, r_flush, word_vec_t'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
